// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame receiver: command codes, status-byte layout,
// the draw-queue entry format and the frame FSM states.
package spi_pkg;

    localparam logic [7:0] CMD_DRAW   = 8'h01;
    localparam logic [7:0] CMD_UPLOAD = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;

    localparam int STAT_OVF_BIT   = 7;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_LVL_W     = 5;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } draw_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DRAW,
        ST_UP_SEL,
        ST_UP_ADDR_H,
        ST_UP_ADDR_L,
        ST_UP_DATA,
        ST_DISCARD
    } state_t;

    // Level field saturates so a full 32-deep queue still fits in five bits.
    function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                               input logic empty, input int unsigned level);
        logic [7:0] s;
        s = '0;
        s[STAT_OVF_BIT]          = ovf;
        s[STAT_FULL_BIT]         = full;
        s[STAT_EMPTY_BIT]        = empty;
        s[STAT_LVL_W-1:0]        = (level > 31) ? 5'd31 : level[STAT_LVL_W-1:0];
        return s;
    endfunction

endpackage

// File: rtl/draw_fifo.sv
// Draw-entry queue, first-word-fall-through; head is zero while empty.
// Latency: push/pop act at the clock edge, head/level visible the following cycle.
// Backpressure: none upstream; a push into a full queue without a pop is dropped and sets sticky overflow.
module draw_fifo
    import spi_pkg::*;
#(
    parameter int  DEPTH = 32,
    parameter type T     = draw_entry_t
) (
    input  logic                     i_core_clk,
    input  logic                     i_arst_n,
    input  logic                     i_push,
    input  T                         i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_clr,
    output T                         o_head_dat,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;
    logic           r_ovf;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_level == (AW+1)'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_core_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
            if (i_push && !w_do_push) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_level    = r_level;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave oversampled in the system clock; decodes draw/upload/clear frames, returns status on MISO.
// Latency: byte strobe SYNC_STAGES+1 cycles after the 8th sck rise; writes/pushes one cycle after that.
// Backpressure: none toward the SPI master; draw pushes into a full queue are dropped and flagged.
module spi_frame_receiver
    import spi_pkg::*;
#(
    parameter int SPRITE_NUM    = 16,
    parameter int SPRITE_ADDR_W = 12,
    parameter int QUEUE_DEPTH   = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            spi_sck,
    input  logic                            spi_mosi,
    input  logic                            spi_cs_n,
    output logic                            spi_miso,
    output logic [$clog2(SPRITE_NUM)-1:0]   sprite_w_select,
    output logic                            sprite_w_en,
    output logic [SPRITE_ADDR_W-1:0]        sprite_w_addr,
    output logic [7:0]                      sprite_w_data,
    input  logic                            dequeue,
    output logic                            is_empty,
    output logic [7:0]                      sprite_id,
    output logic [15:0]                     sprite_x,
    output logic [15:0]                     sprite_y,
    output logic [7:0]                      sprite_scale,
    output logic [$clog2(QUEUE_DEPTH):0]    queue_level,
    output logic                            overflow
);

    localparam int SEL_W = $clog2(SPRITE_NUM);
    localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;

    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_vld;
    logic [7:0]  r_miso_sr;
    logic        r_miso_act;

    state_t                 r_state;
    logic [2:0]             r_grp;
    draw_entry_t            r_entry;
    logic [SEL_W-1:0]       r_sel;
    logic [7:0]             r_addr_hi;
    logic [SPRITE_ADDR_W-1:0] r_ptr;
    logic [SPRITE_ADDR_W-1:0] r_waddr;
    logic [7:0]             r_wdata;
    logic                   r_wen;
    logic                   r_push;
    logic                   r_clr;

    state_t                 w_state_nxt;
    logic [2:0]             w_grp_nxt;
    draw_entry_t            w_entry_nxt;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic [7:0]             w_addr_hi_nxt;
    logic [SPRITE_ADDR_W-1:0] w_ptr_nxt;
    logic [SPRITE_ADDR_W-1:0] w_waddr_nxt;
    logic [7:0]             w_wdata_nxt;
    logic                   w_wen_nxt;
    logic                   w_push_nxt;
    logic                   w_clr_nxt;

    logic        w_sck;
    logic        w_mosi;
    logic        w_cs;
    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_frame_start;
    logic        w_byte_done;
    draw_entry_t w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_overflow;
    logic [LVL_W-1:0] w_level;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= SYNC_STAGES'({r_sck_sync, spi_sck});
            r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, spi_mosi});
            r_cs_sync   <= SYNC_STAGES'({r_cs_sync, spi_cs_n});
            r_sck_prev  <= w_sck;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sck         = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs          = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_rise    = w_sck & ~r_sck_prev & ~w_cs;
    assign w_sck_fall    = ~w_sck & r_sck_prev;
    assign w_frame_start = r_cs_prev & ~w_cs;
    assign w_byte_done   = w_sck_rise & (r_bit_cnt == 3'd7);

    // Deasserted chip select throws away any partially shifted byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_vld <= 1'b0;
        end else if (w_cs) begin
            r_bit_cnt  <= '0;
            r_byte_vld <= 1'b0;
        end else begin
            r_byte_vld <= w_byte_done;
            if (w_sck_rise) begin
                r_shift   <= {r_shift[6:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_miso_sr  <= '0;
            r_miso_act <= 1'b0;
        end else if (w_cs) begin
            r_miso_sr  <= '0;
            r_miso_act <= 1'b0;
        end else if (w_frame_start) begin
            r_miso_sr  <= status_byte(w_overflow, w_full, w_empty, 32'(w_level));
            r_miso_act <= 1'b1;
        end else begin
            if (w_byte_done) r_miso_act <= 1'b0;
            if (w_sck_fall)  r_miso_sr  <= {r_miso_sr[6:0], 1'b0};
        end
    end

    assign spi_miso = r_miso_act & r_miso_sr[7];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grp     <= '0;
            r_entry   <= '0;
            r_sel     <= '0;
            r_addr_hi <= '0;
            r_ptr     <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_push    <= 1'b0;
            r_clr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grp     <= w_grp_nxt;
            r_entry   <= w_entry_nxt;
            r_sel     <= w_sel_nxt;
            r_addr_hi <= w_addr_hi_nxt;
            r_ptr     <= w_ptr_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wen     <= w_wen_nxt;
            r_push    <= w_push_nxt;
            r_clr     <= w_clr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grp_nxt     = r_grp;
        w_entry_nxt   = r_entry;
        w_sel_nxt     = r_sel;
        w_addr_hi_nxt = r_addr_hi;
        w_ptr_nxt     = r_ptr;
        w_waddr_nxt   = r_waddr;
        w_wdata_nxt   = r_wdata;
        w_wen_nxt     = 1'b0;
        w_push_nxt    = 1'b0;
        w_clr_nxt     = 1'b0;
        if (w_cs) begin
            w_state_nxt = ST_IDLE;
            w_grp_nxt   = '0;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_CMD;
        end else if (r_byte_vld) begin
            case (r_state)
                ST_CMD: begin
                    case (r_shift)
                        CMD_DRAW: begin
                            w_state_nxt = ST_DRAW;
                            w_grp_nxt   = '0;
                        end
                        CMD_UPLOAD: w_state_nxt = ST_UP_SEL;
                        CMD_CLEAR: begin
                            w_clr_nxt   = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                        CMD_STATUS: w_state_nxt = ST_DISCARD;
                        default:    w_state_nxt = ST_DISCARD;
                    endcase
                end
                ST_DRAW: begin
                    // The sixth byte completes the entry; r_entry then holds it during the push cycle.
                    case (r_grp)
                        3'd0:    w_entry_nxt.id       = r_shift;
                        3'd1:    w_entry_nxt.x[15:8]  = r_shift;
                        3'd2:    w_entry_nxt.x[7:0]   = r_shift;
                        3'd3:    w_entry_nxt.y[15:8]  = r_shift;
                        3'd4:    w_entry_nxt.y[7:0]   = r_shift;
                        default: begin
                            w_entry_nxt.scale = r_shift;
                            w_push_nxt        = 1'b1;
                        end
                    endcase
                    w_grp_nxt = (r_grp == 3'd5) ? 3'd0 : r_grp + 3'd1;
                end
                ST_UP_SEL: begin
                    w_sel_nxt   = r_shift[SEL_W-1:0];
                    w_state_nxt = ST_UP_ADDR_H;
                end
                ST_UP_ADDR_H: begin
                    w_addr_hi_nxt = r_shift;
                    w_state_nxt   = ST_UP_ADDR_L;
                end
                ST_UP_ADDR_L: begin
                    w_ptr_nxt   = SPRITE_ADDR_W'({r_addr_hi, r_shift});
                    w_state_nxt = ST_UP_DATA;
                end
                ST_UP_DATA: begin
                    w_wen_nxt   = 1'b1;
                    w_waddr_nxt = r_ptr;
                    w_wdata_nxt = r_shift;
                    w_ptr_nxt   = r_ptr + SPRITE_ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    draw_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (draw_entry_t)
    ) u_draw_fifo (
        .i_core_clk (clock),
        .i_arst_n   (reset_n),
        .i_push     (r_push),
        .i_push_dat (r_entry),
        .i_pop      (dequeue),
        .i_clr      (r_clr),
        .o_head_dat (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_level    (w_level),
        .o_overflow (w_overflow)
    );

    assign sprite_w_select = r_sel;
    assign sprite_w_en     = r_wen;
    assign sprite_w_addr   = r_waddr;
    assign sprite_w_data   = r_wdata;
    assign is_empty        = w_empty;
    assign sprite_id       = w_head.id;
    assign sprite_x        = w_head.x;
    assign sprite_y        = w_head.y;
    assign sprite_scale    = w_head.scale;
    assign queue_level     = w_level;
    assign overflow        = w_overflow;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: bit-banged SPI frames, immediate assertions on every observation.
module tb_spi_frame_receiver;
    import spi_pkg::*;

    localparam int HALF = 4;
    localparam int SYNC = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        dequeue = 1'b0;
    logic        spi_miso;
    logic [3:0]  sprite_w_select;
    logic        sprite_w_en;
    logic [11:0] sprite_w_addr;
    logic [7:0]  sprite_w_data;
    logic        is_empty;
    logic [7:0]  sprite_id;
    logic [15:0] sprite_x;
    logic [15:0] sprite_y;
    logic [7:0]  sprite_scale;
    logic [5:0]  queue_level;
    logic        overflow;

    spi_frame_receiver #(
        .SPRITE_NUM(16), .SPRITE_ADDR_W(12), .QUEUE_DEPTH(32), .SYNC_STAGES(SYNC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .sprite_w_select(sprite_w_select),
        .sprite_w_en(sprite_w_en), .sprite_w_addr(sprite_w_addr), .sprite_w_data(sprite_w_data),
        .dequeue(dequeue), .is_empty(is_empty), .sprite_id(sprite_id), .sprite_x(sprite_x),
        .sprite_y(sprite_y), .sprite_scale(sprite_scale), .queue_level(queue_level),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          wr_n = 0;
    logic [11:0] wr_addr [16];
    logic [7:0]  wr_data [16];
    logic [3:0]  wr_sel  [16];
    int          wr_cyc  [16];
    always @(negedge clock) begin
        if (sprite_w_en === 1'b1 && wr_n < 16) begin
            wr_addr[wr_n] = sprite_w_addr;
            wr_data[wr_n] = sprite_w_data;
            wr_sel[wr_n]  = sprite_w_select;
            wr_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int last_rise = 0;
    logic [7:0] m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        dequeue = 1'b0;
    endtask

    // Mode 0: MOSI set while sck low, MISO sampled just before the rising edge.
    task automatic spi_byte(input logic [7:0] b, input int nbits, input bit deq_at_push,
                            output logic [7:0] miso_b);
        miso_b = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = b[i];
            for (int j = 0; j < HALF; j++) tick();
            miso_b[i] = spi_miso;
            spi_sck = 1'b1;
            last_rise = cyc;
            for (int j = 1; j <= HALF; j++) begin
                tick();
                if (deq_at_push && i == 0 && j == SYNC + 2) dequeue = 1'b1;
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] d;
        spi_byte(b, 8, 1'b0, d);
    endtask

    task automatic entry(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] s);
        send(id); send(x[15:8]); send(x[7:0]); send(y[15:8]); send(y[7:0]); send(s);
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        for (int j = 0; j < HALF; j++) tick();
    endtask

    task automatic frame_end();
        for (int j = 0; j < HALF; j++) tick();
        spi_cs_n = 1'b1;
        for (int j = 0; j < 2 * HALF; j++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int base;
        int r_aa;
        logic [7:0] k8;
        logic [11:0] exp_addr [3];
        logic [7:0]  exp_data [3];
        exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000;
        exp_data[0] = 8'hAA;   exp_data[1] = 8'hBB;   exp_data[2] = 8'hCC;

        // reset state
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_miso", 32'(spi_miso), 32'd0);
        chk("rst_wen", 32'(sprite_w_en), 32'd0);
        chk("rst_sel", 32'(sprite_w_select), 32'd0);
        chk("rst_addr", 32'(sprite_w_addr), 32'd0);
        chk("rst_data", 32'(sprite_w_data), 32'd0);
        chk("rst_empty", 32'(is_empty), 32'd1);
        chk("rst_level", 32'(queue_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_head", {sprite_id, sprite_x[7:0], sprite_y[7:0], sprite_scale}, 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        repeat (4) tick();

        // single draw entry
        frame_begin();
        spi_byte(8'h01, 8, 1'b0, m);
        chk("t1_status", 32'(m), 32'h20);
        entry(8'h07, 16'd100, 16'd50, 8'h02);
        frame_end();
        chk("t1_id", 32'(sprite_id), 32'h07);
        chk("t1_x", 32'(sprite_x), 32'd100);
        chk("t1_y", 32'(sprite_y), 32'd50);
        chk("t1_scale", 32'(sprite_scale), 32'd2);
        chk("t1_empty", 32'(is_empty), 32'd0);
        chk("t1_level", 32'(queue_level), 32'd1);
        chk("t1_miso_idle", 32'(spi_miso), 32'd0);

        // upload with address wrap
        base = wr_n;
        frame_begin();
        spi_byte(8'h02, 8, 1'b0, m);
        chk("t2_status", 32'(m), 32'h01);
        send(8'h03); send(8'h0F); send(8'hFE); send(8'hAA);
        r_aa = last_rise;
        send(8'hBB); send(8'hCC);
        frame_end();
        chk("t2_nwr", 32'(wr_n - base), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("t2_sel", 32'(wr_sel[base+k]), 32'd3);
            chk("t2_addr", 32'(wr_addr[base+k]), 32'(exp_addr[k]));
            chk("t2_data", 32'(wr_data[base+k]), 32'(exp_data[k]));
        end
        chk("t2_latency", 32'(wr_cyc[base] - r_aa), 32'(SYNC + 2));

        // drain, then overfill with 33 entries
        dequeue = 1'b1;
        tick();
        chk("t3_drain_empty", 32'(is_empty), 32'd1);
        chk("t3_drain_level", 32'(queue_level), 32'd0);
        frame_begin();
        send(8'h01);
        for (int k = 0; k < 33; k++) begin
            k8 = 8'(k);
            entry(k8, {8'h10, k8}, {8'h20, k8}, k8);
        end
        frame_end();
        chk("t3_level", 32'(queue_level), 32'd32);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_head_id", 32'(sprite_id), 32'd0);
        chk("t3_head_x", 32'(sprite_x), 32'h1000);
        frame_begin();
        spi_byte(8'h04, 8, 1'b0, m);
        chk("t3_status", 32'(m), 32'hDF);
        send(8'h55);
        frame_end();
        chk("t3_level_after_status", 32'(queue_level), 32'd32);

        // push and pop together while full
        frame_begin();
        send(8'h01); send(8'h40); send(8'h00); send(8'h40); send(8'h00); send(8'h41);
        spi_byte(8'h42, 8, 1'b1, m);
        frame_end();
        chk("t4_level", 32'(queue_level), 32'd32);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_head_id", 32'(sprite_id), 32'd1);
        chk("t4_head_x", 32'(sprite_x), 32'h1001);
        for (int k = 0; k < 31; k++) begin
            dequeue = 1'b1;
            tick();
        end
        chk("t4_tail_level", 32'(queue_level), 32'd1);
        chk("t4_tail_id", 32'(sprite_id), 32'h40);
        chk("t4_tail_x", 32'(sprite_x), 32'h0040);
        chk("t4_tail_y", 32'(sprite_y), 32'h0041);
        chk("t4_tail_scale", 32'(sprite_scale), 32'h42);

        // chip select raised mid-entry, then clear
        frame_begin();
        send(8'h01); send(8'h55); send(8'h00);
        spi_byte(8'h12, 4, 1'b0, m);
        spi_cs_n = 1'b1;
        for (int j = 0; j < 2 * HALF; j++) tick();
        chk("t5_abort_level", 32'(queue_level), 32'd1);
        chk("t5_abort_id", 32'(sprite_id), 32'h40);
        frame_begin();
        spi_byte(8'h03, 8, 1'b0, m);
        chk("t5_status", 32'(m), 32'h81);
        frame_end();
        chk("t5_clr_level", 32'(queue_level), 32'd0);
        chk("t5_clr_ovf", 32'(overflow), 32'd0);
        chk("t5_clr_empty", 32'(is_empty), 32'd1);
        chk("t5_clr_head", 32'(sprite_id), 32'd0);

        // reset during an upload
        base = wr_n;
        frame_begin();
        send(8'h02); send(8'h05); send(8'h00); send(8'h10); send(8'h11); send(8'h22);
        tick();
        reset_n = 1'b0;
        tick();
        chk("t6_rst_wen", 32'(sprite_w_en), 32'd0);
        chk("t6_rst_addr", 32'(sprite_w_addr), 32'd0);
        chk("t6_rst_sel", 32'(sprite_w_select), 32'd0);
        chk("t6_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        for (int j = 0; j < 2 * HALF; j++) tick();
        send(8'h33);
        frame_end();
        chk("t6_nwr", 32'(wr_n - base), 32'd2);
        chk("t6_wr0", {wr_sel[base], wr_addr[base], wr_data[base]}, {4'h5, 12'h010, 8'h11});
        chk("t6_wr1", {wr_sel[base+1], wr_addr[base+1], wr_data[base+1]}, {4'h5, 12'h011, 8'h22});
        frame_begin();
        spi_byte(8'h01, 8, 1'b0, m);
        chk("t6_status", 32'(m), 32'h20);
        entry(8'h21, 16'h1234, 16'h0BCD, 8'h80);
        frame_end();
        chk("t6_id", 32'(sprite_id), 32'h21);
        chk("t6_x", 32'(sprite_x), 32'h1234);
        chk("t6_y", 32'(sprite_y), 32'h0BCD);
        chk("t6_scale", 32'(sprite_scale), 32'h80);
        chk("t6_level", 32'(queue_level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Parametrised SPI slave front-end: the single-clock successor to the current SPI driver path. Oversamples the SPI pins in the `clock` domain, so no BUFG'd SPI clock is needed. Decodes framed commands into:
- sprite-storage writes,
- draw-entry pushes into an internal parametrised FIFO,
- queue clears.

It also returns a status byte on MISO. It sits between the MCU SPI pins and `sprite_storage` / the renderer, replacing the reader, write-controller and queue trio.

## Interface
- `SPRITE_NUM`, 16, number of sprite slots; select width is `$clog2(SPRITE_NUM)`
- `SPRITE_ADDR_W`, 12, sprite-storage byte-address width
- `QUEUE_DEPTH`, 32, draw FIFO entries; power of two, ≥ 2
- `SYNC_STAGES`, 2, synchroniser flops on `spi_sck`, `spi_mosi` and `spi_cs_n`

Ports:
- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `spi_sck`  in  1  SPI clock, mode 0; requires f_sck ≤ f_clock/8
- `spi_mosi`  in  1  master out, MSB first
- `spi_cs_n`  in  1  chip select, active low
- `spi_miso`  out  1  status output
- `sprite_w_select`  out  `$clog2(SPRITE_NUM)`  sprite slot to write
- `sprite_w_en`  out  1  one-cycle write strobe
- `sprite_w_addr`  out  `SPRITE_ADDR_W`  write address
- `sprite_w_data`  out  8  write data (two 4-bit pixels)
- `dequeue`  in  1  pop head entry
- `is_empty`  out  1  FIFO empty
- `sprite_id`  out  8  head entry id
- `sprite_x`  out  16  head entry x
- `sprite_y`  out  16  head entry y
- `sprite_scale`  out  8  head entry scale
- `queue_level`  out  `$clog2(QUEUE_DEPTH)+1`  current occupancy
- `overflow`  out  1  sticky: a push was dropped

## Operation
- **Sampling**
  - Synchronised `sck` rising edge shifts MOSI into an 8-bit shift register.
  - Synchronised falling edge advances MISO.
  - Eighth rising edge produces a one-cycle `byte_valid` with the byte.
- **Frame boundaries**
  - Synchronised `cs_n` falling edge starts a frame: bit counter cleared, state → CMD.
  - Synchronised `cs_n` high forces IDLE, discards any partial byte and any partial draw entry.
- **States**
  - IDLE: waits for `cs_n` low, then goes to CMD.
  - CMD: the first byte selects the next state.
    - `0x01` → DRAW.
    - `0x02` → UP_SEL.
    - `0x03` → clear FIFO and `overflow`, then DISCARD.
    - `0x04` → DISCARD (status-only frame).
    - Any other value → DISCARD.
  - DRAW: bytes are collected in 6-byte groups: id, x[15:8], x[7:0], y[15:8], y[7:0], scale.
    - The 6th byte pushes one entry and the group counter returns to 0.
    - Any number of entries per frame is allowed.
  - UP_SEL: byte[`$clog2(SPRITE_NUM)`-1:0] → select; upper bits are ignored. Next state UP_ADDR_H.
  - UP_ADDR_H, then UP_ADDR_L: big-endian start address, truncated to `SPRITE_ADDR_W`. Next state UP_DATA.
  - UP_DATA: each byte raises `sprite_w_en` with the current address, then the address increments, wrapping modulo 2^`SPRITE_ADDR_W`.
  - DISCARD: consumes bytes until `cs_n` goes high.
- **FIFO**
  - First-word-fall-through: head fields are valid whenever `is_empty` = 0.
  - `dequeue` while empty is ignored.
  - Push while full with no pop: entry dropped, `overflow` set.
  - Push and pop in the same cycle while full: both take effect, level unchanged.
  - Push and pop in the same cycle while empty: the push is stored, the pop is ignored.
  - A clear coinciding with a `dequeue` leaves the FIFO empty.
- **MISO status**
  - Captured at frame start: {`overflow`, full, `is_empty`, min(level, 31)[4:0]}.
  - Shifted out MSB first during the command byte.
  - Bit 7 is driven at frame start; later bits are driven on falling edges.
  - `spi_miso` = 0 after the command byte and while `cs_n` is high.

## Timing
- **Reset values:** `spi_miso` 0, `sprite_w_en` 0, `sprite_w_select` 0, `sprite_w_addr` 0, `sprite_w_data` 0, `is_empty` 1, `queue_level` 0, `overflow` 0, head fields 0, state IDLE.
- **Byte latency:** `byte_valid` asserts `SYNC_STAGES`+1 cycles after the pin-level 8th `sck` rise.
- **Write strobe:** `sprite_w_en` is registered and asserts the cycle after `byte_valid`. Addr, data and select are stable in that same cycle.
- **Push latency:** the push takes effect the cycle after the 6th `byte_valid`. `is_empty` falls and the head becomes valid one cycle after that.
- **Dequeue:** registered at the `clock` edge; the next head is visible the following cycle.
- **Clear:** happens the cycle after the `0x03` byte completes. A push in that same cycle is impossible, because the clear only follows a command byte.
- **`cs_n` rise mid-byte:** no strobe is generated for the partial byte.
- **`reset_n` low at any point:** all state clears immediately.

## Structure
- **Package `spi_pkg`:**
  - Command constants `CMD_DRAW`, `CMD_UPLOAD`, `CMD_CLEAR`, `CMD_STATUS`.
  - Packed struct `draw_entry_t`: id 8, x 16, y 16, scale 8.
  - Status-byte bit positions.
  - State enum.
- **Sub-module `draw_fifo`:** parametrised by depth and `draw_entry_t`. Provides push, pop, clear, level, full and empty.
- **Kept in the top level:** the synchronisers and the frame FSM.

## Test plan
- Reset, then a frame `01 07 00 64 00 32 02` → one entry: id 7, x 100, y 50, scale 2; `is_empty` 0; `queue_level` 1.
- Frame `02 03 0F FE AA BB CC` with `SPRITE_ADDR_W`=12 → three writes, select 3: 0xFFE←AA, 0xFFF←BB, 0x000←CC (wrap).
- 33 draw entries with `QUEUE_DEPTH`=32 → level 32, `overflow` 1. A `04` frame then returns MISO 0xDF (overflow, full, level clamped to 31).
- Full FIFO, with `dequeue` asserted in the same cycle as a push → level stays 32, new entry becomes the tail, `overflow` unchanged.
- `cs_n` raised after 4 bits of byte 3 of a draw entry → no push. The next frame `03` → level 0, `overflow` 0, `is_empty` 1.
- `reset_n` pulsed low mid-upload → `sprite_w_en` 0 and state IDLE. A following `01` frame is decoded normally.
